// File: rtl/fetch_queue_pkg.sv
// Shared pipeline definitions for the fetch front end:
// widths, instruction field positions and the queued fetch entry.
package fetch_queue_pkg;

    localparam int ADDR_W  = 8;
    localparam int INSTR_W = 16;

    localparam int OPC_HI = 15;
    localparam int OPC_LO = 11;
    localparam int RD_HI  = 10;
    localparam int RD_LO  = 8;
    localparam int R1_HI  = 7;
    localparam int R1_LO  = 4;
    localparam int R2_HI  = 3;
    localparam int R2_LO  = 0;

    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fq_fifo.sv
// Register FIFO holding fetched {pc, instr} entries.
// Clear drops all entries by snapping the read pointer to the write pointer.
module fq_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 24,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          push,
    input  logic [W-1:0]  push_data,
    input  logic          pop,
    output logic [W-1:0]  head,
    output logic [CW-1:0] count
);

    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push, do_pop;

    always_comb begin
        do_push  = push & ~clr;
        do_pop   = pop & ~clr & (count_q != '0);
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (clr) begin
            rd_ptr_d = wr_ptr_q;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            if (do_push && !do_pop) begin
                count_d = count_q + 1'b1;
            end else if (!do_push && do_pop) begin
                count_d = count_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;

    // Occupancy includes the in-flight read, so a push never meets a full queue.
    push_into_full: assert property (
        @(posedge clk) disable iff (rst)
        push |-> (count_q != CW'(DEPTH))
    );

endmodule

// File: rtl/fetch_queue.sv
// Fetch PC, single outstanding ROM read and decoupling queue to decode.
// Redirect squashes the queue and the in-flight read and restarts fetch.
module fetch_queue #(
    parameter int DEPTH   = 4,
    parameter int ADDR_W  = fetch_queue_pkg::ADDR_W,
    parameter int INSTR_W = fetch_queue_pkg::INSTR_W
) (
    input  logic               clk,
    input  logic               rst,
    output logic [ADDR_W-1:0]  rom_addr,
    output logic               rom_en,
    input  logic [INSTR_W-1:0] rom_instr,
    input  logic               redirect,
    input  logic [ADDR_W-1:0]  redirect_addr,
    input  logic               stall,
    output logic               out_valid,
    output logic [ADDR_W-1:0]  out_pc,
    output logic [INSTR_W-1:0] out_instr,
    output logic [4:0]         out_opcode,
    output logic [2:0]         out_rd,
    output logic [3:0]         out_r1,
    output logic [3:0]         out_r2
);

    import fetch_queue_pkg::*;

    localparam int CW = $clog2(DEPTH + 1);
    localparam int EW = ADDR_W + INSTR_W;
    localparam logic [CW:0] DEPTH_L = (CW + 1)'(DEPTH);

    logic [ADDR_W-1:0] fpc_q, fpc_d;
    logic [ADDR_W-1:0] inflight_pc_q, inflight_pc_d;
    logic              inflight_v_q, inflight_v_d;
    logic              deq, enq, issue;
    logic [CW:0]       occ;
    logic [CW-1:0]     count;
    logic [EW-1:0]     head;

    always_comb begin
        deq   = out_valid & ~stall & ~redirect;
        enq   = inflight_v_q & ~redirect;
        occ   = {1'b0, count}
              + {{CW{1'b0}}, inflight_v_q}
              - {{CW{1'b0}}, deq};
        issue = ~redirect & (occ < DEPTH_L);

        fpc_d         = fpc_q;
        inflight_pc_d = inflight_pc_q;
        inflight_v_d  = issue;
        if (redirect) begin
            fpc_d = redirect_addr;
        end else if (issue) begin
            fpc_d         = fpc_q + 1'b1;
            inflight_pc_d = fpc_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fpc_q         <= '0;
            inflight_pc_q <= '0;
            inflight_v_q  <= 1'b0;
        end else begin
            fpc_q         <= fpc_d;
            inflight_pc_q <= inflight_pc_d;
            inflight_v_q  <= inflight_v_d;
        end
    end

    fq_fifo #(
        .DEPTH (DEPTH),
        .W     (EW)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .clr       (redirect),
        .push      (enq),
        .push_data ({inflight_pc_q, rom_instr}),
        .pop       (deq),
        .head      (head),
        .count     (count)
    );

    assign rom_addr   = fpc_q;
    assign rom_en     = issue;
    assign out_valid  = (count != '0);
    assign out_pc     = out_valid ? head[EW-1:INSTR_W] : '0;
    assign out_instr  = out_valid ? head[INSTR_W-1:0] : '0;
    assign out_opcode = out_instr[OPC_HI:OPC_LO];
    assign out_rd     = out_instr[RD_HI:RD_LO];
    assign out_r1     = out_instr[R1_HI:R1_LO];
    assign out_r2     = out_instr[R2_HI:R2_LO];

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Instruction fetch queue sitting between the synchronous instruction ROM and the IF/ID pipeline register. It owns the fetch PC, issues one ROM read per cycle while space remains, and buffers returned instructions tagged with their address. It presents them to decode with a valid/stall handshake, so decode stalls no longer freeze fetch. A branch or jump redirect squashes everything in flight and restarts fetch at the target.

## Interface

- DEPTH, 4, queue entries; power of two, at least 2
- ADDR_W, 8, instruction address width
- INSTR_W, 16, instruction width

- clk  in  1  rising-edge clock
- rst  in  1  reset, asynchronous, active-high
- rom_addr  out  ADDR_W  ROM read address, always equal to the fetch PC register
- rom_en  out  1  a fetch is issued this cycle
- rom_instr  in  INSTR_W  ROM data; registered, valid the cycle after rom_addr is sampled
- redirect  in  1  branch/jump taken; restart fetch
- redirect_addr  in  ADDR_W  redirect target
- stall  in  1  decode cannot accept this cycle
- out_valid  out  1  head entry valid
- out_pc  out  ADDR_W  head entry address
- out_instr  out  INSTR_W  head entry instruction
- out_opcode / out_rd / out_r1 / out_r2  out  5/3/4/4  out_instr[15:11] / [10:8] / [7:4] / [3:0]

## Operation

- Registers:
  - fpc (fetch PC)
  - inflight_v and inflight_pc (one outstanding ROM read)
  - FIFO of {pc, instr}: rd_ptr, wr_ptr, count (0..DEPTH)
- Dequeue: deq = out_valid & !stall & !redirect.
- Issue: rom_en = !redirect & (count + inflight_v - deq < DEPTH). On issue, fpc <= fpc + 1 (mod 2^ADDR_W; 0xFF wraps to 0x00), inflight_v <= 1, inflight_pc <= fpc. With no issue, inflight_v <= 0.
- Enqueue: when inflight_v & !redirect, write {inflight_pc, rom_instr} at wr_ptr.
- Overflow is impossible because occupancy counts the in-flight read. An enqueue into a full queue is a design error; flag it with an assertion.
- Simultaneous enqueue and dequeue: count unchanged, both pointers advance.
- Redirect (highest priority, overrides stall and every other action):
  - fpc <= redirect_addr
  - count <= 0, rd_ptr <= wr_ptr
  - inflight_v <= 0; the ROM data returning next cycle is discarded
  - no enqueue, dequeue or issue in the redirect cycle
- out_valid = (count != 0). out_pc and out_instr show the head entry when valid and are driven to 0 when invalid.
- Pointers wrap modulo DEPTH.

## Timing

- Reset values: fpc = 0, rom_addr = 0, rom_en = 1 in the first post-reset cycle, inflight_v = 0, count = 0, out_valid = 0, out_pc = 0, out_instr = 0.
- Redirect latency: redirect high in cycle T (sampled at edge E0).
  - T+1: rom_addr = target, issue
  - T+2: rom_instr valid, enqueued at E2
  - T+3: out_valid = 1, out_pc = target
- Reset follows the same path: the first instruction (address 0) reaches out_valid in the third cycle after rst deasserts.
- Steady state: one instruction per cycle with stall low.
- Stall: the queue fills to DEPTH entries, then rom_en drops. When stall releases, issue resumes in the same cycle the dequeue fires.
- rst asserted mid-operation clears all state immediately; outputs take their reset values without waiting for a clock edge.

## Structure

- Shared package (pipeline package): ADDR_W, INSTR_W, instruction field slice constants (OPCODE [15:11], RD [10:8], R1 [7:4], R2 [3:0]), and a fetch-entry struct {pc, instr}.
- One sub-module is natural: fq_fifo, a DEPTH-entry register FIFO with clear, push, pop and count.
- Fetch-control logic (fpc, in-flight tracking, issue) lives in fetch_queue itself.

## Test plan

- Reset, then stall low, with a ROM model holding instr = 0x1000 | addr -> out_pc 0,1,2,… on consecutive cycles from the 3rd cycle; out_instr = 0x1000, 0x1001, …
- Hold stall high for 10 cycles -> count saturates at 4 and rom_en stays 0. Release stall -> out_pc continues with no gap or duplicate.
- Redirect to 0x40 while the queue holds 3 entries -> out_valid = 0 for cycles T+1..T+2, then out_pc = 0x40, 0x41; the squashed in-flight instruction never appears.
- Redirect together with stall and a full queue -> redirect wins; the queue empties and out_pc = target at T+3.
- Redirect to 0xFE -> out_pc sequence 0xFE, 0xFF, 0x00, 0x01 (fpc wrap).
- Assert rst asynchronously mid-stream -> out_valid and rom_addr go to 0 immediately; after release, fetch restarts at 0.
